// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data memory controller: MEM_* op codes and FSM states.
// No timing of its own; pure definitions.
// No flow control; consumed by dmem_ctrl and dmem_lane_fmt.
package dmem_ctrl_pkg;

    // Load op codes (we must be 0)
    localparam logic [3:0] MEM_LW  = 4'd0;
    localparam logic [3:0] MEM_LH  = 4'd1;
    localparam logic [3:0] MEM_LHU = 4'd2;
    localparam logic [3:0] MEM_LB  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    // Store op codes (we must be 1)
    localparam logic [3:0] MEM_SW  = 4'd8;
    localparam logic [3:0] MEM_SH  = 4'd9;
    localparam logic [3:0] MEM_SB  = 4'd10;

    typedef enum logic [1:0] {
        DMEM_INIT = 2'd0,
        DMEM_IDLE = 2'd1,
        DMEM_WAIT = 2'd2,
        DMEM_RESP = 2'd3
    } dmem_state_e;

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: load extraction/extension, store byte enables and lane-replicated write data, illegal-op detection.
// Purely combinational, zero latency.
// No flow control. Misaligned trap enabled by macro DMEM_MISALIGN_TRAP_EN; otherwise low bits are masked to natural alignment.
module dmem_lane_fmt
    import dmem_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic        we_i,
    input  logic [1:0]  byte_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [15:0] half;
    logic [7:0]  bytev;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (((op_i == MEM_LW) || (op_i == MEM_SW)) && (byte_i != 2'b00)) ||
                      (((op_i == MEM_LH) || (op_i == MEM_LHU) || (op_i == MEM_SH)) && byte_i[0]);
`endif

    // Decode op into lane data; any illegal request yields no enables and zero data
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        err_o   = 1'b0;
        half    = byte_i[1] ? word_i[31:16] : word_i[15:0];
        bytev   = word_i[{byte_i, 3'b000} +: 8];
        case (op_i)
            MEM_LW:           rdata_o = word_i;
            MEM_LH, MEM_LHU:  rdata_o = {{16{half[15] & (op_i == MEM_LH)}}, half};
            MEM_LB, MEM_LBU:  rdata_o = {{24{bytev[7] & (op_i == MEM_LB)}}, bytev};
            MEM_SW: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            MEM_SH: begin
                be_o    = byte_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            MEM_SB: begin
                be_o    = 4'b0001 << byte_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default:          err_o = 1'b1;
        endcase
        if (op_is_store(op_i) != we_i) begin
            err_o = 1'b1;
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        if (misalign) begin
            err_o = 1'b1;
        end
`endif
        if (err_o) begin
            be_o    = 4'b0000;
            wdata_o = 32'h0;
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory controller: zero-fills after reset, then serves one load/store at a time with sub-word access.
// Response strobe arrives LATENCY+1 cycles after the accepting edge; throughput one request per LATENCY+2 cycles.
// req_ready is high only in IDLE; requests offered at other times are ignored, never queued. Optional DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT_W = $clog2(LATENCY + 1);

    dmem_state_e       state_q, state_d;
    logic [IDX_W-1:0]  fill_q, fill_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        op_q, op_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              init_q, init_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    logic [3:0]        ln_be;
    logic [31:0]       ln_wdata;
    logic [31:0]       ln_rdata;
    logic              ln_err;

    // Address bits above the memory span alias onto it
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    dmem_lane_fmt u_lane (
        .op_i    (op_q),
        .we_i    (we_q),
        .byte_i  (addr_q[1:0]),
        .wdata_i (wdata_q),
        .word_i  (mem[addr_q[IDX_W+1:2]]),
        .be_o    (ln_be),
        .wdata_o (ln_wdata),
        .rdata_o (ln_rdata),
        .err_o   (ln_err)
    );

    // Control state; reset drops any in-flight store and restarts the zero-fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_INIT;
            fill_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            init_q  <= init_d;
        end
    end

    // Next-state, request capture, memory write port and handshake outputs
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        init_d     = init_q;
        mem_we     = 1'b0;
        mem_idx    = addr_q[IDX_W+1:2];
        mem_be     = ln_be;
        mem_wdata  = ln_wdata;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            DMEM_INIT: begin
                mem_we    = 1'b1;
                mem_idx   = fill_q;
                mem_be    = 4'b1111;
                mem_wdata = 32'h0;
                fill_d    = fill_q + IDX_W'(1);
                if (fill_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    init_d  = 1'b1;
                    state_d = DMEM_IDLE;
                end
            end
            DMEM_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    op_d    = req_op;
                    addr_d  = req_addr[IDX_W+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    state_d = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = we_q & ~ln_err;
                    rdata_d = (we_q | ln_err) ? 32'h0 : ln_rdata;
                    err_d   = ln_err;
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            DMEM_RESP: begin
                resp_valid = 1'b1;
                state_d    = DMEM_IDLE;
            end
            default: state_d = DMEM_INIT;
        endcase
    end

    // Byte-enabled write port; unselected bytes keep their contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign init_done  = init_q;

endmodule
